// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow clock in I_CLK cycles
// Also flags lock on two identical measurements and timeout when S_CLK stops.
module clk_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             I_CLK,
    input  logic             Rst,
    input  logic             S_CLK,
    output logic [CNT_W-1:0] O_PERIOD,
    output logic [CNT_W-1:0] O_HIGH,
    output logic             O_VALID,
    output logic             O_LOCK,
    output logic             O_TIMEOUT
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t           state_q, state_d;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             first_done_q, first_done_d;
    logic             prev_valid_q;
    logic             publish;
    logic             timeout_hit;

    // s1/s2 resolve metastability; s3 is history for edge detection.
    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= S_CLK;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            per_q        <= '0;
            hi_q         <= '0;
            first_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_q        <= per_d;
            hi_q         <= hi_d;
            first_done_q <= first_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        per_d        = per_q;
        hi_d         = hi_q;
        first_done_d = first_done_q;
        publish      = 1'b0;
        timeout_hit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_HIGH;
                    per_d        = ONE;
                    hi_d         = ONE;
                    first_done_d = 1'b0;
                end
            end
            ST_HIGH, ST_LOW: begin
                // A rise in HIGH means the fall was missed; it is handled like a rise in LOW.
                if (rise) begin
                    state_d = ST_HIGH;
                    per_d   = ONE;
                    hi_d    = ONE;
                    if (first_done_q) begin
                        publish = 1'b1;
                    end else begin
                        first_done_d = 1'b1;
                    end
                end else if (per_q == TIMEOUT_C) begin
                    state_d     = ST_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    per_d = per_q + ONE;
                    if (state_q == ST_HIGH) begin
                        if (fall) begin
                            state_d = ST_LOW;
                        end else begin
                            hi_d = hi_q + ONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            O_PERIOD     <= '0;
            O_HIGH       <= '0;
            O_VALID      <= 1'b0;
            O_LOCK       <= 1'b0;
            O_TIMEOUT    <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            O_VALID <= publish;
            if (publish) begin
                O_PERIOD     <= per_q;
                O_HIGH       <= hi_q;
                O_TIMEOUT    <= 1'b0;
                O_LOCK       <= prev_valid_q && (per_q == O_PERIOD) && (hi_q == O_HIGH);
                prev_valid_q <= 1'b1;
            end else if (timeout_hit) begin
                O_TIMEOUT <= 1'b1;
                O_LOCK    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - randomized scoreboard bench for clk_period_meter
// Expected events come from an edge-list model of the sampled S_CLK levels.
module tb_clk_period_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 100;

    logic             I_CLK = 1'b0;
    logic             Rst   = 1'b1;
    logic             S_CLK = 1'b0;
    logic [CNT_W-1:0] O_PERIOD;
    logic [CNT_W-1:0] O_HIGH;
    logic             O_VALID;
    logic             O_LOCK;
    logic             O_TIMEOUT;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .I_CLK    (I_CLK),
        .Rst      (Rst),
        .S_CLK    (S_CLK),
        .O_PERIOD (O_PERIOD),
        .O_HIGH   (O_HIGH),
        .O_VALID  (O_VALID),
        .O_LOCK   (O_LOCK),
        .O_TIMEOUT(O_TIMEOUT)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        bit is_to;
        int cyc;
        int per;
        int hi;
        bit lock;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  rst_q  = 1'b1;

    always @(posedge I_CLK) begin
        cyc   = cyc + 1;
        rst_q = Rst;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model state: edges are indexed by the I_CLK edge that samples S_CLK.
    int m_prev_v, m_active, m_rises, m_last_rise, m_fallseen, m_last_fall;
    int m_pv, m_pp, m_ph;

    task automatic model_step(input int k, input bit v, input bit r);
        ev_t e;
        int  p, h;
        if (r) begin
            m_prev_v = 0; m_active = 0; m_pv = 0; m_pp = 0; m_ph = 0;
            return;
        end
        if (v && !m_prev_v) begin
            if (!m_active) begin
                m_active = 1;
                m_rises  = 1;
            end else begin
                p = k - m_last_rise;
                h = m_fallseen ? (m_last_fall - m_last_rise) : p;
                if (m_rises >= 2) begin
                    e.is_to = 0; e.cyc = k + 2; e.per = p; e.hi = h;
                    e.lock  = m_pv && (p == m_pp) && (h == m_ph);
                    exp_q.push_back(e);
                    m_pv = 1; m_pp = p; m_ph = h;
                end else begin
                    m_rises = 2;
                end
            end
            m_last_rise = k;
            m_fallseen  = 0;
        end else if (m_active && (k - m_last_rise) == TO) begin
            e.is_to = 1; e.cyc = k + 2; e.per = m_pp; e.hi = m_ph; e.lock = 0;
            exp_q.push_back(e);
            m_active = 0;
        end
        if (!v && m_prev_v && m_active && !m_fallseen) begin
            m_fallseen  = 1;
            m_last_fall = k;
        end
        m_prev_v = v;
    endtask

    task automatic drive(input bit v);
        S_CLK = v;
        model_step(cyc + 1, v, Rst);
        @(negedge I_CLK);
    endtask

    task automatic period(input int lo, input int hi);
        repeat (lo) drive(1'b0);
        repeat (hi) drive(1'b1);
    endtask

    bit  exp_to  = 1'b0;
    bit  to_seen = 1'b0;
    ev_t mon_e;

    always @(negedge I_CLK) begin
        if (rst_q) begin
            chk("rst_valid", O_VALID, 0);
            chk("rst_lock", O_LOCK, 0);
            chk("rst_timeout", O_TIMEOUT, 0);
            chk("rst_period", O_PERIOD, 0);
            chk("rst_high", O_HIGH, 0);
            exp_to  = 1'b0;
            to_seen = 1'b0;
        end else begin
            if (O_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("valid_kind", 0, mon_e.is_to);
                    chk("valid_cycle", cyc, mon_e.cyc);
                    chk("valid_period", O_PERIOD, mon_e.per);
                    chk("valid_high", O_HIGH, mon_e.hi);
                    chk("valid_lock", O_LOCK, mon_e.lock);
                    exp_to = 1'b0;
                end
            end
            if (O_TIMEOUT && !to_seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_timeout", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("timeout_kind", 1, mon_e.is_to);
                    chk("timeout_cycle", cyc, mon_e.cyc);
                    chk("timeout_period_held", O_PERIOD, mon_e.per);
                    chk("timeout_high_held", O_HIGH, mon_e.hi);
                    chk("timeout_lock", O_LOCK, 0);
                    exp_to = 1'b1;
                end
            end
            to_seen = O_TIMEOUT;
            chk("timeout_level", O_TIMEOUT, exp_to);
        end
    end

    initial begin
        int lo, hi;
        @(negedge I_CLK);
        Rst = 1'b1;
        repeat (3) drive(1'b0);
        Rst = 1'b0;

        repeat (6) period(2, 2);
        repeat (5) period(7, 3);
        repeat (4) period(2, 2);
        repeat (4) period(3, 3);

        repeat (3) drive(1'b1);
        repeat (120) drive(1'b0);
        repeat (5) period(3, 3);

        repeat (130) drive(1'b1);
        repeat (5) period(4, 2);

        repeat (3) period(3, 3);
        repeat (3) drive(1'b0);
        repeat (4) drive(1'b1);
        Rst = 1'b1;
        repeat (2) drive(1'b1);
        Rst = 1'b0;
        repeat (5) period(3, 3);

        lo = 2;
        hi = 2;
        repeat (40) begin
            if ($urandom_range(0, 1) == 1) begin
                lo = $urandom_range(2, 12);
                hi = $urandom_range(2, 12);
            end
            period(lo, hi);
        end

        repeat (115) drive(1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
